// File: rtl/sonar_echo_gen.sv
// rtl/sonar_echo_gen.sv - ultrasonic ranger emulator: qualified trigger, delayed echo of programmable width, holdoff
// Optional feature macro SONAR_NOECHO_TIMEOUT_EN: zero width yields a TIMEOUT-cycle "no echo" pulse.
module sonar_echo_gen #(
   parameter int TRIG_MIN  = 10,
   parameter int BURST_DLY = 400,
   parameter int HOLDOFF   = 2000,
   parameter int TIMEOUT   = 38000,
   parameter int W         = 16
) (
   input  logic         clk,
   input  logic         reset_l,
   input  logic         trigger,
   input  logic [W-1:0] width_in,
   input  logic         width_load,
   output logic         echo,
   output logic         busy,
   output logic [7:0]   short_trig_cnt
);
   localparam int CW = (W > 16) ? W : 16;

   typedef enum logic [2:0] {IDLE, ARM, DELAY, ECHO, HOLD} state_t;

   state_t        state;
   logic          trig_m;
   logic          trig_s;
   logic [W-1:0]  shadow_w;
   logic [W-1:0]  active_w;
   logic [CW-1:0] cnt;
   logic [CW-1:0] pulse_last;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         trig_m <= 1'b0;
         trig_s <= 1'b0;
      end else begin
         trig_m <= trigger;
         trig_s <= trig_m;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l)
         shadow_w <= '0;
      else if (width_load)
         shadow_w <= width_in;
   end

   // Zero width only reaches ECHO when the timeout pulse is enabled.
   always_comb begin
      pulse_last = (active_w == '0) ? CW'(TIMEOUT - 1) : CW'(active_w) - CW'(1);
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state          <= IDLE;
         cnt            <= '0;
         echo           <= 1'b0;
         busy           <= 1'b0;
         short_trig_cnt <= '0;
         active_w       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trig_s) begin
                  state <= ARM;
                  cnt   <= CW'(1);
               end
            end
            ARM: begin
               if (trig_s) begin
                  if (cnt < CW'(TRIG_MIN))
                     cnt <= cnt + CW'(1);
               end else if (cnt >= CW'(TRIG_MIN)) begin
                  state    <= DELAY;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  active_w <= shadow_w;
               end else begin
                  state <= IDLE;
                  cnt   <= '0;
                  if (short_trig_cnt != 8'hFF)
                     short_trig_cnt <= short_trig_cnt + 8'd1;
               end
            end
            DELAY: begin
               if (cnt == CW'(BURST_DLY - 1)) begin
                  cnt <= '0;
`ifdef SONAR_NOECHO_TIMEOUT_EN
                  state <= ECHO;
                  echo  <= 1'b1;
`else
                  if (active_w != '0) begin
                     state <= ECHO;
                     echo  <= 1'b1;
                  end else begin
                     state <= HOLD;
                  end
`endif
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ECHO: begin
               if (cnt == pulse_last) begin
                  state <= HOLD;
                  echo  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HOLD: begin
               // Holdoff expired: park here until the trigger line is released.
               if (cnt >= CW'(HOLDOFF - 1)) begin
                  if (!trig_s) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     cnt   <= '0;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               echo  <= 1'b0;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sonar_echo_gen.sv
// tb/tb_sonar_echo_gen.sv - randomized self-checking bench for sonar_echo_gen against a transaction-level model
module tb_sonar_echo_gen;
   localparam int TRIG_MIN  = 10;
   localparam int BURST_DLY = 400;
   localparam int HOLDOFF   = 2000;
   localparam int TIMEOUT   = 38000;
   localparam int W         = 16;
`ifdef SONAR_NOECHO_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         clk        = 1'b0;
   logic         reset_l    = 1'b0;
   logic         trigger    = 1'b0;
   logic         width_load = 1'b0;
   logic [W-1:0] width_in   = '0;
   logic         echo;
   logic         busy;
   logic [7:0]   short_trig_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int m_shadow = 0;
   int m_short  = 0;

   sonar_echo_gen #(
      .TRIG_MIN(TRIG_MIN), .BURST_DLY(BURST_DLY), .HOLDOFF(HOLDOFF),
      .TIMEOUT(TIMEOUT), .W(W)
   ) dut (
      .clk(clk), .reset_l(reset_l), .trigger(trigger), .width_in(width_in),
      .width_load(width_load), .echo(echo), .busy(busy), .short_trig_cnt(short_trig_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_w(input int v);
      width_in   = W'(v);
      width_load = 1'b1;
      tick();
      width_load = 1'b0;
      m_shadow   = v;
   endtask

   // One trigger of n_high cycles; k counts edges from e0 (first edge sampling trigger low).
   task automatic txn(input string tag, input int n_high,
                      input int r1s, input int r1e, input int r2s, input int r2e,
                      input int lk, input int lv, input int rk);
      int  len_exp, rise_exp, brise_exp, fall_exp, bound;
      int  rise_k, brise_k, fall_k, len;
      bit  valid;
      rise_k  = -1;
      brise_k = -1;
      fall_k  = -1;
      len     = 0;
      valid     = (n_high >= TRIG_MIN);
      len_exp   = !valid ? 0 : (m_shadow != 0 ? m_shadow : (TO_EN ? TIMEOUT : 0));
      rise_exp  = (len_exp != 0) ? 2 + BURST_DLY : -1;
      brise_exp = valid ? 2 : -1;
      fall_exp  = valid ? 2 + BURST_DLY + len_exp + HOLDOFF : -1;
      bound     = valid ? fall_exp + 20 : 8;
      if (!valid)
         m_short = (m_short < 255) ? m_short + 1 : 255;
      trigger = 1'b1;
      repeat (n_high) tick();
      trigger = 1'b0;
      for (int k = 0; k < bound; k++) begin
         tick();
         if (k == rk) begin
            reset_l    = 1'b0;
            trigger    = 1'b0;
            width_load = 1'b0;
            #1;
            check({tag, "/rst_echo"}, 32'(echo), 32'd0);
            check({tag, "/rst_busy"}, 32'(busy), 32'd0);
            check({tag, "/rst_short"}, 32'(short_trig_cnt), 32'd0);
            m_shadow = 0;
            m_short  = 0;
            repeat (3) tick();
            reset_l = 1'b1;
            repeat (6) tick();
            check({tag, "/post_rst_echo"}, 32'(echo), 32'd0);
            check({tag, "/post_rst_busy"}, 32'(busy), 32'd0);
            return;
         end
         if (echo === 1'b1) begin
            if (rise_k < 0) rise_k = k;
            len++;
         end
         if (busy === 1'b1 && brise_k < 0) brise_k = k;
         if (brise_k >= 0 && busy === 1'b0 && fall_k < 0) fall_k = k;
         trigger    = ((k >= r1s && k < r1e) || (k >= r2s && k < r2e));
         width_load = (k == lk);
         if (k == lk) begin
            width_in = W'(lv);
            m_shadow = lv;
         end
      end
      trigger    = 1'b0;
      width_load = 1'b0;
      check({tag, "/rise"}, 32'(rise_k), 32'(rise_exp));
      check({tag, "/len"}, 32'(len), 32'(len_exp));
      check({tag, "/busy_rise"}, 32'(brise_k), 32'(brise_exp));
      check({tag, "/busy_fall"}, 32'(fall_k), 32'(fall_exp));
      check({tag, "/short"}, 32'(short_trig_cnt), 32'(m_short));
   endtask

   initial begin
      repeat (2) tick();
      check("reset/echo", 32'(echo), 32'd0);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/short", 32'(short_trig_cnt), 32'd0);
      reset_l = 1'b1;
      repeat (2) tick();

      txn("short5", 5, -1, -1, -1, -1, -1, 0, -1);
      txn("short_min_m1", TRIG_MIN - 1, -1, -1, -1, -1, -1, 0, -1);
      load_w($urandom_range(1, 200));
      txn("valid_min", TRIG_MIN, -1, -1, -1, -1, -1, 0, -1);
      for (int i = 0; i < 298; i++)
         txn("short_rnd", $urandom_range(1, TRIG_MIN - 1), -1, -1, -1, -1, -1, 0, -1);
      check("short_sat", 32'(short_trig_cnt), 32'd255);

      load_w(2000);
      txn("reset_mid_echo", 20, -1, -1, -1, -1, -1, 0, 900);

      load_w(5000);
      txn("w5000", 20, -1, -1, -1, -1, -1, 0, -1);

      load_w(1000);
      txn("retrig", 15, 600, 640, 1502, 1507, -1, 0, -1);

      load_w(3000);
      txn("load_mid_echo", 12, -1, -1, -1, -1, 1000, 100, -1);
      txn("next_pulse", 12, -1, -1, -1, -1, -1, 0, -1);

      for (int i = 0; i < 3; i++) begin
         load_w($urandom_range(1, 400));
         txn("rnd_valid", $urandom_range(TRIG_MIN, 30), -1, -1, -1, -1, -1, 0, -1);
      end

      load_w(0);
      txn("width0", 12, -1, -1, -1, -1, -1, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
